// File: rtl/sim_video_pkg.sv
// Shared types and pixel packing for the simulation video capture tap.
package sim_video_pkg;

  localparam int FMT_RGB888   = 0;
  localparam int FMT_RGB565   = 1;
  localparam int FMT_ABGR8888 = 2;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Unused upper bits of the 32-bit framebuffer word stay zero (alpha excepted).
  function automatic logic [31:0] pack_pixel(input int fmt, input rgb8_t px);
    logic [31:0] v;
    case (fmt)
      FMT_RGB565:   v = {16'h0000, px.r[7:3], px.g[7:2], px.b[7:3]};
      FMT_ABGR8888: v = {8'hFF, px.b, px.g, px.r};
      default:      v = {8'h00, px.r, px.g, px.b};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Rise/fall detector whose history only advances on pixel-enable cycles.
module vid_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ce,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else if (i_ce) begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_ce & i_d & ~r_prev;
  assign o_fall = i_ce & ~i_d & r_prev;

endmodule

// File: rtl/sim_video_capture.sv
// Video tap: writes active pixels to a framebuffer port one clk after sampling and
// measures active width/height per frame; never stalls, the core video is never backpressured.
module sim_video_capture
  import sim_video_pkg::*;
#(
  parameter int COLOR_W    = 8,
  parameter int PIX_FMT    = 0,
  parameter int MAX_W      = 1024,
  parameter int MAX_H      = 768,
  parameter int FRAME_SKIP = 0,
  parameter int ADDR_W     = 20
) (
  input  logic               i_clk_sys,
  input  logic               i_reset,
  input  logic               i_ce_pix,
  input  logic [COLOR_W-1:0] i_r,
  input  logic [COLOR_W-1:0] i_g,
  input  logic [COLOR_W-1:0] i_b,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_hb,
  input  logic               i_vb,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [31:0]        o_fb_data,
  output logic               o_frame_done,
  output logic [15:0]        o_frame_count,
  output logic [15:0]        o_active_w,
  output logic [15:0]        o_active_h,
  output logic               o_clipped,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_hb,
  output logic               o_vb
);

  localparam logic [15:0] MAX_W16 = 16'(MAX_W);
  localparam logic [15:0] MAX_H16 = 16'(MAX_H);
  localparam int SKIP_W = $clog2(FRAME_SKIP + 2);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);

  cap_state_t        r_state;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [15:0]       r_line_w;
  logic [ADDR_W-1:0] r_line_base;
  logic [SKIP_W-1:0] r_skip;

  rgb8_t       w_rgb;
  logic [15:0] w_line_w_max;
  logic        w_hb_rise;
  logic        w_vb_rise;
  logic        w_vb_fall;
  logic        w_unused_hb_fall;

  if (COLOR_W >= 8) begin : g_trunc
    assign w_rgb = {i_r[7:0], i_g[7:0], i_b[7:0]};
  end else begin : g_zext
    assign w_rgb = {{(8-COLOR_W){1'b0}}, i_r, {(8-COLOR_W){1'b0}}, i_g, {(8-COLOR_W){1'b0}}, i_b};
  end

  vid_edge_det u_hb_edge (
    .i_clk   (i_clk_sys),
    .i_reset (i_reset),
    .i_ce    (i_ce_pix),
    .i_d     (i_hb),
    .o_rise  (w_hb_rise),
    .o_fall  (w_unused_hb_fall)
  );

  vid_edge_det u_vb_edge (
    .i_clk   (i_clk_sys),
    .i_reset (i_reset),
    .i_ce    (i_ce_pix),
    .i_d     (i_vb),
    .o_rise  (w_vb_rise),
    .o_fall  (w_vb_fall)
  );

  assign w_line_w_max = (r_x > r_line_w) ? r_x : r_line_w;

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state       <= ST_SYNC;
      r_x           <= '0;
      r_y           <= '0;
      r_line_w      <= '0;
      r_line_base   <= '0;
      r_skip        <= '0;
      o_fb_we       <= 1'b0;
      o_fb_addr     <= '0;
      o_fb_data     <= '0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
      o_active_w    <= '0;
      o_active_h    <= '0;
      o_clipped     <= 1'b0;
      o_hs          <= 1'b0;
      o_vs          <= 1'b0;
      o_hb          <= 1'b0;
      o_vb          <= 1'b0;
    end else begin
      o_fb_we      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_ce_pix) begin
        o_hs <= i_hs;
        o_vs <= i_vs;
        o_hb <= i_hb;
        o_vb <= i_vb;
        if (r_state == ST_SYNC) begin
          if (w_vb_fall) begin
            r_state <= ST_ACTIVE;
          end
        end else if (w_vb_rise) begin
          // Frame end wins over a coincident hb edge; the open line is folded in here.
          o_active_w    <= w_line_w_max;
          o_active_h    <= r_y + 16'(r_x != 16'd0);
          o_frame_done  <= 1'b1;
          o_frame_count <= o_frame_count + 16'd1;
          r_x           <= '0;
          r_y           <= '0;
          r_line_w      <= '0;
          r_line_base   <= '0;
          r_skip        <= (r_skip == SKIP_LAST) ? '0 : r_skip + 1'b1;
        end else if (w_hb_rise) begin
          if (r_x != 16'd0) begin
            r_y         <= r_y + 16'd1;
            r_line_base <= r_line_base + ADDR_W'(MAX_W);
          end
          r_line_w <= w_line_w_max;
          r_x      <= '0;
        end else if (!i_hb && !i_vb) begin
          r_x <= r_x + 16'd1;
          if (r_x < MAX_W16 && r_y < MAX_H16) begin
            o_fb_we   <= (r_skip == '0);
            o_fb_addr <= r_line_base + ADDR_W'(r_x);
            o_fb_data <= pack_pixel(PIX_FMT, w_rgb);
          end else begin
            o_clipped <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_video_capture.sv
// Drives three capture taps (RGB888 / RGB565+clip+skip / ABGR+row clip) from one video source.
module tb_sim_video_capture;

  typedef struct packed {
    logic        hs;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] aw;
    logic [15:0] ah;
    logic        clip;
  } fexp_t;

  localparam int NH = 4;

  logic       clk = 1'b0;
  logic       rst, ce, hs, vs, hb, vb;
  logic [7:0] r, g, b;
  logic       ce_d = 1'b0;

  logic        fb_we[3], done[3], clip[3], hs_o[3], vs_o[3], hb_o[3], vb_o[3];
  logic [31:0] dat[3];
  logic [15:0] cnt[3], aw[3], ah[3];
  logic [19:0] addr0, addr1;
  logic [7:0]  addr2;

  int mw[3]  = '{1024, 4, 16};
  int mh[3]  = '{768, 768, 3};
  int sk[3]  = '{0, 1, 0};
  int fmt[3] = '{0, 1, 2};

  exp_t  wq[3][$];
  fexp_t fq[3][$];
  int    fc_m[3], skp[3], ewr[3], nwr[3];
  bit    clip_m[3];
  logic [31:0] a0[3];
  bit    synced, vb_last, ce_tog;
  int    nw, fw;
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ce_d <= ce;

  sim_video_capture #(.COLOR_W(8), .PIX_FMT(0), .MAX_W(1024), .MAX_H(768), .FRAME_SKIP(0), .ADDR_W(20)) u_dut0 (
    .i_clk_sys(clk), .i_reset(rst), .i_ce_pix(ce), .i_r(r), .i_g(g), .i_b(b),
    .i_hs(hs), .i_vs(vs), .i_hb(hb), .i_vb(vb),
    .o_fb_we(fb_we[0]), .o_fb_addr(addr0), .o_fb_data(dat[0]), .o_frame_done(done[0]),
    .o_frame_count(cnt[0]), .o_active_w(aw[0]), .o_active_h(ah[0]), .o_clipped(clip[0]),
    .o_hs(hs_o[0]), .o_vs(vs_o[0]), .o_hb(hb_o[0]), .o_vb(vb_o[0]));

  sim_video_capture #(.COLOR_W(8), .PIX_FMT(1), .MAX_W(4), .MAX_H(768), .FRAME_SKIP(1), .ADDR_W(20)) u_dut1 (
    .i_clk_sys(clk), .i_reset(rst), .i_ce_pix(ce), .i_r(r), .i_g(g), .i_b(b),
    .i_hs(hs), .i_vs(vs), .i_hb(hb), .i_vb(vb),
    .o_fb_we(fb_we[1]), .o_fb_addr(addr1), .o_fb_data(dat[1]), .o_frame_done(done[1]),
    .o_frame_count(cnt[1]), .o_active_w(aw[1]), .o_active_h(ah[1]), .o_clipped(clip[1]),
    .o_hs(hs_o[1]), .o_vs(vs_o[1]), .o_hb(hb_o[1]), .o_vb(vb_o[1]));

  sim_video_capture #(.COLOR_W(8), .PIX_FMT(2), .MAX_W(16), .MAX_H(3), .FRAME_SKIP(0), .ADDR_W(8)) u_dut2 (
    .i_clk_sys(clk), .i_reset(rst), .i_ce_pix(ce), .i_r(r), .i_g(g), .i_b(b),
    .i_hs(hs), .i_vs(vs), .i_hb(hb), .i_vb(vb),
    .o_fb_we(fb_we[2]), .o_fb_addr(addr2), .o_fb_data(dat[2]), .o_frame_done(done[2]),
    .o_frame_count(cnt[2]), .o_active_w(aw[2]), .o_active_h(ah[2]), .o_clipped(clip[2]),
    .o_hs(hs_o[2]), .o_vs(vs_o[2]), .o_hb(hb_o[2]), .o_vb(vb_o[2]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int f, input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    case (f)
      1:       return {16'h0000, pr[7:3], pg[7:2], pb[7:3]};
      2:       return {8'hFF, pb, pg, pr};
      default: return {8'h00, pr, pg, pb};
    endcase
  endfunction

  task automatic mon(input int d);
    logic [31:0] a;
    exp_t  e;
    fexp_t f;
    a = (d == 0) ? 32'(addr0) : (d == 1) ? 32'(addr1) : 32'(addr2);
    if (fb_we[d]) begin
      nwr[d]++;
      check_eq($sformatf("d%0d_we_on_ce", d), ce_d, 1);
      check_eq($sformatf("d%0d_we_blank", d), {hb_o[d], vb_o[d], vs_o[d]}, 0);
      check_eq($sformatf("d%0d_we_expected", d), wq[d].size() > 0, 1);
      if (wq[d].size() > 0) begin
        e = wq[d].pop_front();
        check_eq($sformatf("d%0d_addr", d), a, e.addr);
        check_eq($sformatf("d%0d_data", d), dat[d], e.data);
        check_eq($sformatf("d%0d_hs", d), hs_o[d], e.hs);
      end
      if (a == 0) a0[d] = dat[d];
    end
    if (done[d]) begin
      check_eq($sformatf("d%0d_done_expected", d), fq[d].size() > 0, 1);
      if (fq[d].size() > 0) begin
        f = fq[d].pop_front();
        check_eq($sformatf("d%0d_frame_count", d), cnt[d], f.cnt);
        check_eq($sformatf("d%0d_active_w", d), aw[d], f.aw);
        check_eq($sformatf("d%0d_active_h", d), ah[d], f.ah);
        check_eq($sformatf("d%0d_clipped", d), clip[d], f.clip);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic rst_chk();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("d%0d_rst_ctl", d),
               {fb_we[d], done[d], clip[d], hs_o[d], vs_o[d], hb_o[d], vb_o[d], cnt[d], aw[d], ah[d]}, 0);
      check_eq($sformatf("d%0d_rst_data", d), dat[d], 0);
    end
    check_eq("rst_addr", {addr0, addr1, addr2}, 0);
  endtask

  task automatic slot(input bit shb, input bit svb, input int x, input int y);
    logic [7:0] pr, pg, pb;
    bit         phs;
    @(negedge clk);
    if (x == 0 && y == 0) begin
      pr = 8'hFF; pg = 8'h80; pb = 8'h08;
    end else begin
      pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
    end
    phs = 1'($urandom);
    ce = 1'b1; hb = shb; vb = svb; vs = svb; hs = phs;
    r = pr; g = pg; b = pb;
    if (!shb && !svb && synced) begin
      for (int d = 0; d < 3; d++) begin
        if (x >= mw[d] || y >= mh[d]) begin
          clip_m[d] = 1'b1;
        end else if (skp[d] == 0) begin
          wq[d].push_back('{hs: phs, addr: 32'(y * mw[d] + x), data: pk(fmt[d], pr, pg, pb)});
          ewr[d]++;
        end
      end
    end
    if (ce_tog) begin
      @(negedge clk);
      ce = 1'b0;
      hb = 1'($urandom); vb = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ce = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_chk();
    rst = 1'b0;
    synced = 1'b0;
    for (int d = 0; d < 3; d++) begin
      fc_m[d] = 0; skp[d] = 0; clip_m[d] = 1'b0;
    end
  endtask

  task automatic line(input bit lvb, input int y, input int rst_pix);
    // First blanking line after an active region marks the end of that frame.
    if (lvb && !vb_last && synced) begin
      for (int d = 0; d < 3; d++) begin
        fc_m[d]++;
        fq[d].push_back('{cnt: 16'(fc_m[d]), aw: 16'(fw), ah: 16'(NH), clip: clip_m[d]});
        skp[d] = (skp[d] == sk[d]) ? 0 : skp[d] + 1;
      end
    end
    if (!lvb && vb_last) synced = 1'b1;
    vb_last = lvb;
    slot(1'b1, lvb, -1, y);
    slot(1'b1, lvb, -1, y);
    for (int x = 0; x < nw; x++) begin
      slot(1'b0, lvb, x, y);
      if (x == rst_pix) do_reset();
    end
    if (!lvb) fw = nw;
  endtask

  task automatic frame(input int rst_line, input int rst_pix);
    for (int v = 0; v < 2; v++) line(1'b1, 0, -1);
    for (int y = 0; y < NH; y++) line(1'b0, y, (y == rst_line) ? rst_pix : -1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; hs = 1'b0; vs = 1'b0; hb = 1'b0; vb = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    synced = 1'b0; vb_last = 1'b0; ce_tog = 1'b0; nw = 8; fw = 0;
    for (int d = 0; d < 3; d++) begin
      fc_m[d] = 0; skp[d] = 0; ewr[d] = 0; nwr[d] = 0; clip_m[d] = 1'b0; a0[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_chk();
    rst = 1'b0;

    ce_tog = 1'b0; nw = 8;
    repeat (4) frame(-1, -1);
    ce_tog = 1'b1; nw = 6;
    repeat (2) frame(-1, -1);
    ce_tog = 1'b0; nw = 8;
    repeat (2) frame(-1, -1);
    frame(1, 3);
    frame(-1, -1);
    line(1'b1, 0, -1);
    repeat (5) @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("d%0d_write_total", d), nwr[d], ewr[d]);
      check_eq($sformatf("d%0d_writes_pending", d), wq[d].size(), 0);
      check_eq($sformatf("d%0d_frames_pending", d), fq[d].size(), 0);
      check_eq($sformatf("d%0d_count_end", d), cnt[d], fc_m[d]);
    end
    check_eq("rgb888_px00", a0[0], 32'h00FF8008);
    check_eq("rgb565_px00", a0[1], 32'h0000FC01);
    check_eq("abgr_px00", a0[2], 32'hFF0880FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
